// File: rtl/button_press_emitter_pkg.sv
// button_press_emitter_pkg: shared state encodings and widths for the pushbutton emitter
package button_press_emitter_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, PRESS = 2'b01, GAP = 2'b10} state_t;
  localparam int TIMER_W = 8;
  localparam int PEND_W = 3;
endpackage

// File: rtl/button_press_emitter_sat_updown_counter.sv
// sat_updown_counter: saturating up/down counter with registered drop pulse
module sat_updown_counter
  import button_press_emitter_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  input  logic [PEND_W-1:0] max,
  output logic [PEND_W-1:0] count,
  output logic              overflow
);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= inc && !dec && count == max;
      if (inc && !dec && count != max) count <= count + 1'b1;
      else if (dec && !inc && count != '0) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/button_press_emitter.sv
// button_press_emitter: turns queued request pulses into fixed-width active-low button presses
module button_press_emitter
  import button_press_emitter_pkg::*;
#(
  parameter int PRESS_CYCLES = 4,
  parameter int GAP_CYCLES = 2,
  parameter int QUEUE_MAX = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              request,
  output logic              button_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow,
  output logic [7:0]        presses_done
);
  if (PRESS_CYCLES < 1 || PRESS_CYCLES > 255 || GAP_CYCLES < 1 || GAP_CYCLES > 255 ||
      QUEUE_MAX < 1 || QUEUE_MAX > 7) begin : g_bad_params
    $error("button_press_emitter: parameter out of range");
  end
  localparam logic [TIMER_W-1:0] PRESS_LOAD = TIMER_W'(PRESS_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_CYCLES - 1);
  state_t state, state_nx;
  logic [TIMER_W-1:0] tcnt, tcnt_nx;
  logic start, done;
  sat_updown_counter u_queue (
    .clock(clock),
    .reset(reset),
    .inc(request),
    .dec(start),
    .max(PEND_W'(QUEUE_MAX)),
    .count(pending),
    .overflow(overflow)
  );
  always_comb begin
    state_nx = state;
    tcnt_nx = tcnt;
    start = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: start = pending != '0;
      PRESS:
        if (tcnt != '0) tcnt_nx = tcnt - 1'b1;
        else begin
          state_nx = GAP;
          tcnt_nx = GAP_LOAD;
          done = 1'b1;
        end
      GAP:
        if (tcnt != '0) tcnt_nx = tcnt - 1'b1;
        else if (pending != '0) start = 1'b1;
        else state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (start) begin
      state_nx = PRESS;
      tcnt_nx = PRESS_LOAD;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      tcnt <= '0;
      presses_done <= '0;
    end else begin
      state <= state_nx;
      tcnt <= tcnt_nx;
      if (done) presses_done <= presses_done + 1'b1;
    end
  end
  assign button_out = state != PRESS;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_button_press_emitter.sv
// tb_button_press_emitter: directed vector table plus hand sequences for overflow and mid-press reset
module tb_button_press_emitter;
  logic clock, reset, request;
  logic button_out, busy, overflow;
  logic [2:0] pending;
  logic [7:0] presses_done;
  int checks = 0;
  int errors = 0;
  int releases = 0;
  typedef struct {
    logic       req;
    logic       btn;
    logic       bsy;
    logic [2:0] pend;
    logic [7:0] pd;
    logic       ovf;
  } vec_t;
  vec_t vecs[$];
  button_press_emitter dut (
    .clock(clock),
    .reset(reset),
    .request(request),
    .button_out(button_out),
    .busy(busy),
    .pending(pending),
    .overflow(overflow),
    .presses_done(presses_done)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge button_out) releases++;
  function automatic void add(int n, logic req, logic btn, logic bsy, int pend, int pd, logic ovf);
    for (int i = 0; i < n; i++) vecs.push_back('{req, btn, bsy, 3'(pend), 8'(pd), ovf});
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask
  task automatic check_all(string tag, logic btn, logic bsy, int pend, int pd, logic ovf);
    check({tag, ".button_out"}, 32'(button_out), 32'(btn));
    check({tag, ".busy"}, 32'(busy), 32'(bsy));
    check({tag, ".pending"}, 32'(pending), 32'(pend));
    check({tag, ".presses_done"}, 32'(presses_done), 32'(pd));
    check({tag, ".overflow"}, 32'(overflow), 32'(ovf));
  endtask
  initial begin
    int ovf_n, base, k;
    reset = 1'b1;
    request = 1'b0;
    // single request: press on edges 1..4, gap 5..6, idle from 7
    add(1, 1, 1, 0, 1, 0, 0);
    add(4, 0, 0, 1, 0, 0, 0);
    add(2, 0, 1, 1, 0, 1, 0);
    add(2, 0, 1, 0, 0, 1, 0);
    // burst of three, period 6 with no idle between presses
    add(1, 1, 1, 0, 1, 1, 0);
    add(1, 1, 0, 1, 1, 1, 0);
    add(1, 1, 0, 1, 2, 1, 0);
    add(2, 0, 0, 1, 2, 1, 0);
    add(2, 0, 1, 1, 2, 2, 0);
    add(4, 0, 0, 1, 1, 2, 0);
    add(2, 0, 1, 1, 1, 3, 0);
    add(4, 0, 0, 1, 0, 3, 0);
    add(2, 0, 1, 1, 0, 4, 0);
    add(1, 0, 1, 0, 0, 4, 0);
    // request lands on the gap-end dequeue edge: pending holds at 1
    add(1, 1, 1, 0, 1, 4, 0);
    add(1, 1, 0, 1, 1, 4, 0);
    add(3, 0, 0, 1, 1, 4, 0);
    add(2, 0, 1, 1, 1, 5, 0);
    add(1, 1, 0, 1, 1, 5, 0);
    add(3, 0, 0, 1, 1, 5, 0);
    add(2, 0, 1, 1, 1, 6, 0);
    add(4, 0, 0, 1, 0, 6, 0);
    add(2, 0, 1, 1, 0, 7, 0);
    add(1, 0, 1, 0, 0, 7, 0);
    tick();
    check_all("reset", 1, 0, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_all("idle", 1, 0, 0, 0, 0);
    end
    foreach (vecs[i]) begin
      request = vecs[i].req;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].btn, vecs[i].bsy, 32'(vecs[i].pend), 32'(vecs[i].pd), vecs[i].ovf);
    end
    request = 1'b0;
    // ten back-to-back requests: two dequeued in flight, seven queued, tenth dropped
    ovf_n = 0;
    request = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (overflow) ovf_n++;
      if (i == 8) check("ovf.pending_full", 32'(pending), 32'd7);
      if (i == 9) check("ovf.pulse", 32'(overflow), 32'd1);
    end
    request = 1'b0;
    k = 0;
    while (busy && k < 200) begin
      tick();
      if (overflow) ovf_n++;
      k++;
    end
    check("ovf.drain_timeout", 32'(busy), 32'd0);
    check("ovf.pulses", 32'(ovf_n), 32'd1);
    check("ovf.presses_done", 32'(presses_done), 32'd16);
    check("ovf.pending_empty", 32'(pending), 32'd0);
    // reset asynchronously during the second press cycle with two requests still queued
    request = 1'b1;
    tick();
    tick();
    check("rst.first_press", 32'(button_out), 32'd0);
    tick();
    request = 1'b0;
    check("rst.queued", 32'(pending), 32'd2);
    base = releases;
    #1 reset = 1'b1;
    #1;
    check_all("rst.async", 1, 0, 0, 0, 0);
    check("rst.truncated_release", 32'(releases - base), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    request = 1'b1;
    tick();
    request = 1'b0;
    k = 0;
    do begin
      tick();
      k++;
    end while (busy && k < 30);
    check("rst.after_timeout", 32'(busy), 32'd0);
    check("rst.after_releases", 32'(releases - base), 32'd2);
    check("rst.after_presses_done", 32'(presses_done), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
